// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM state type and op-class helpers for muldiv_unit
package muldiv_pkg;
  localparam logic [2:0] OP_MUL   = 3'd0;
  localparam logic [2:0] OP_MULH  = 3'd1;
  localparam logic [2:0] OP_MULHU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_MOD   = 3'd4;
  localparam logic [2:0] OP_DIVU  = 3'd5;
  localparam logic [2:0] OP_MODU  = 3'd6;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  function automatic logic is_div(input logic [2:0] op);
    return op inside {OP_DIV, OP_MOD, OP_DIVU, OP_MODU};
  endfunction
  function automatic logic is_signed_op(input logic [2:0] op);
    return !(op inside {OP_MULHU, OP_DIVU, OP_MODU});
  endfunction
  function automatic logic is_rem(input logic [2:0] op);
    return op inside {OP_MOD, OP_MODU};
  endfunction
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response handshake bundle for muldiv_unit, flush included
interface muldiv_if #(parameter int WIDTH = 32);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_src1;
  logic [WIDTH-1:0] in_src2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  modport master(output flush, in_valid, in_op, in_src1, in_src2, out_ready,
                 input in_ready, out_valid, out_result);
  modport slave(input flush, in_valid, in_op, in_src1, in_src2, out_ready,
                output in_ready, out_valid, out_result);
endinterface

// File: rtl/muldiv_div_core.sv
// muldiv_div_core: unsigned restoring divider, one quotient bit per cycle over WIDTH cycles
module muldiv_div_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             last,
  output logic [WIDTH-1:0] q_next,
  output logic [WIDTH-1:0] r_next
);
  logic [WIDTH:0]   rem, rem_n;
  logic [WIDTH-1:0] quo, dvs;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH+1:0] rem_sh, diff;
  logic             ge;
  // One extra guard bit on the subtraction so the borrow is the sign
  assign rem_sh = {rem, quo[WIDTH-1]};
  assign diff   = rem_sh - {2'b00, dvs};
  assign ge     = ~diff[WIDTH+1];
  assign rem_n  = ge ? diff[WIDTH:0] : rem_sh[WIDTH:0];
  assign q_next = {quo[WIDTH-2:0], ge};
  assign r_next = rem_n[WIDTH-1:0];
  assign last   = cnt == CNT_W'(1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      cnt <= '0;
    end else if (start) begin
      rem <= '0;
      quo <= dividend;
      dvs <= divisor;
      cnt <= CNT_W'(WIDTH);
    end else if (cnt != '0) begin
      rem <= rem_n;
      quo <= q_next;
      cnt <= cnt - CNT_W'(1);
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MUL/MULH/MULHU/DIV/MOD/DIVU/MODU unit with valid/ready and flush
// Optional MULDIV_DIVZERO_BYPASS_EN: divide-by-zero result produced at accept (1-cycle latency)
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic     clk,
  input logic     reset,
  muldiv_if.slave bus
);
  state_t state, state_n;
  logic [2:0]         op;
  logic [WIDTH-1:0]   a, b, result, mag1, mag2, q_next, r_next, div_res, mul_res, byp_res;
  logic               s1, s2, in_s1, in_s2, div_in, accept, last, byp;
  logic [2*WIDTH-1:0] x1, x2, prod;
  assign div_in = is_div(bus.in_op);
  assign in_s1  = is_signed_op(bus.in_op) & bus.in_src1[WIDTH-1];
  assign in_s2  = is_signed_op(bus.in_op) & bus.in_src2[WIDTH-1];
  assign mag1   = in_s1 ? -bus.in_src1 : bus.in_src1;
  assign mag2   = in_s2 ? -bus.in_src2 : bus.in_src2;
  assign accept = state == S_IDLE && bus.in_valid && !bus.flush;
`ifdef MULDIV_DIVZERO_BYPASS_EN
  logic rem_in;
  assign rem_in  = is_rem(bus.in_op);
  assign byp     = div_in && bus.in_src2 == '0;
  assign byp_res = rem_in ? bus.in_src1 : (in_s1 ? {{(WIDTH-1){1'b0}}, 1'b1} : '1);
`else
  assign byp     = 1'b0;
  assign byp_res = '0;
`endif
  muldiv_div_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_div (
    .clk(clk), .reset(reset), .start(accept && div_in && !byp),
    .dividend(mag1), .divisor(mag2), .last(last), .q_next(q_next), .r_next(r_next)
  );
  // Operands kept raw; s1/s2 double as sign-extension bits for the multiply
  assign x1      = {{WIDTH{s1}}, a};
  assign x2      = {{WIDTH{s2}}, b};
  assign prod    = x1 * x2;
  assign mul_res = (op == OP_MULH || op == OP_MULHU) ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
  assign div_res = is_rem(op) ? (s1 ? -r_next : r_next) : ((s1 ^ s2) ? -q_next : q_next);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (bus.in_valid) state_n = div_in ? (byp ? S_DONE : S_DIV) : S_MUL;
      S_MUL:  state_n = S_DONE;
      S_DIV:  if (last) state_n = S_DONE;
      S_DONE: if (bus.out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (bus.flush) state_n = S_IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op     <= OP_MUL;
      a      <= '0;
      b      <= '0;
      s1     <= 1'b0;
      s2     <= 1'b0;
      result <= '0;
    end else begin
      if (accept) begin
        op <= bus.in_op;
        a  <= bus.in_src1;
        b  <= bus.in_src2;
        s1 <= in_s1;
        s2 <= in_s2;
      end
      if (accept && byp) result <= byp_res;
      if (state == S_MUL) result <= mul_res;
      if (state == S_DIV && last) result <= div_res;
    end
  end
  assign bus.in_ready   = state == S_IDLE;
  assign bus.out_valid  = state == S_DONE;
  assign bus.out_result = result;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit at WIDTH=32 with hand-computed results
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
`ifdef MULDIV_DIVZERO_BYPASS_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif
  localparam int MLAT = 2;
  localparam int DLAT = 33;
  muldiv_if #(.WIDTH(32)) bus ();
  muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] r, input int lat);
    int n;
    logic busy_ok;
    @(negedge clk);
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_src1  = x;
    bus.in_src2  = y;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_op    = 3'($urandom);
    bus.in_src1  = $urandom;
    bus.in_src2  = $urandom;
    n = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (!bus.out_valid && bus.in_ready) busy_ok = 1'b0;
    end while (!bus.out_valid && n < 100);
    check({tag, ".lat"}, 32'(n), 32'(lat));
    check({tag, ".res"}, bus.out_result, r);
    check({tag, ".busy"}, 32'(busy_ok), 32'd1);
  endtask
  initial begin
    logic [31:0] hold;
    logic        ok_v, ok_r, ok_i, seen;
    int          n;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_op = 3'd0;
    bus.in_src1 = '0; bus.in_src2 = '0; bus.out_ready = 1'b1;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst.in_ready", 32'(bus.in_ready), 32'd1);
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.out_result", bus.out_result, 32'd0);
    reset = 1'b0;
    // multiply
    run("mulh_min",  3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MLAT);
    run("mulhu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MLAT);
    run("mulh_m1",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MLAT);
    run("mul_7x-3",  3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MLAT);
    run("op7_mul",   3'd7, 32'd5, 32'd6, 32'd30, MLAT);
    // divide
    run("div_-7_2",   3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DLAT);
    run("mod_-7_2",   3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DLAT);
    run("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, DLAT);
    run("modu_100_7", 3'd6, 32'd100, 32'd7, 32'd2, DLAT);
    run("div_ovf",    3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, DLAT);
    run("mod_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, DLAT);
    // divide by zero
    run("divu_5_0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, ZLAT);
    run("modu_5_0", 3'd6, 32'd5, 32'd0, 32'd5, ZLAT);
    run("mod_-5_0", 3'd4, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, ZLAT);
    run("div_-5_0", 3'd3, 32'hFFFF_FFFB, 32'd0, 32'd1, ZLAT);
    run("div_5_0",  3'd3, 32'd5, 32'd0, 32'hFFFF_FFFF, ZLAT);
    // backpressure: result held, new requests ignored
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_op = 3'd0; bus.in_src1 = 32'd6; bus.in_src2 = 32'd7;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.out_valid && n < 100);
    check("bp.lat", 32'(n), 32'(MLAT));
    hold = bus.out_result;
    check("bp.res", hold, 32'd42);
    ok_v = 1'b1; ok_r = 1'b1; ok_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1; bus.in_op = 3'd0; bus.in_src1 = 32'd1; bus.in_src2 = 32'd1;
      @(negedge clk);
      if (!bus.out_valid) ok_v = 1'b0;
      if (bus.out_result !== hold) ok_r = 1'b0;
      if (bus.in_ready) ok_i = 1'b0;
    end
    check("bp.valid_held", 32'(ok_v), 32'd1);
    check("bp.result_held", 32'(ok_r), 32'd1);
    check("bp.ready_low", 32'(ok_i), 32'd1);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp.handoff_valid", 32'(bus.out_valid), 32'd0);
    check("bp.handoff_ready", 32'(bus.in_ready), 32'd1);
    run("bp.after", 3'd0, 32'd9, 32'd9, 32'd81, MLAT);
    // flush mid-divide
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = 3'd5; bus.in_src1 = 32'd100; bus.in_src2 = 32'd7;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    check("flush.valid", 32'(bus.out_valid), 32'd0);
    check("flush.ready", 32'(bus.in_ready), 32'd1);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (bus.out_valid) seen = 1'b1; end
    check("flush.no_result", 32'(seen), 32'd0);
    run("flush.mul3x4", 3'd0, 32'd3, 32'd4, 32'd12, MLAT);
    // flush coinciding with accept drops the request
    @(negedge clk);
    bus.in_valid = 1'b1; bus.flush = 1'b1; bus.in_op = 3'd0; bus.in_src1 = 32'd2; bus.in_src2 = 32'd2;
    @(posedge clk);
    #1 begin bus.in_valid = 1'b0; bus.flush = 1'b0; end
    check("flush_acc.ready", 32'(bus.in_ready), 32'd1);
    seen = 1'b0;
    repeat (5) begin @(negedge clk); if (bus.out_valid) seen = 1'b1; end
    check("flush_acc.no_result", 32'(seen), 32'd0);
    // flush while a result waits in DONE
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_op = 3'd0; bus.in_src1 = 32'd2; bus.in_src2 = 32'd3;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.out_valid && n < 100);
    check("flush_done.valid_before", 32'(bus.out_valid), 32'd1);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 begin bus.flush = 1'b0; bus.out_ready = 1'b1; end
    check("flush_done.valid_after", 32'(bus.out_valid), 32'd0);
    check("flush_done.ready_after", 32'(bus.in_ready), 32'd1);
    // asynchronous reset mid-divide
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = 3'd3; bus.in_src1 = 32'hFFFF_FFF9; bus.in_src2 = 32'd2;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst.in_ready", 32'(bus.in_ready), 32'd1);
    check("arst.out_valid", 32'(bus.out_valid), 32'd0);
    check("arst.out_result", bus.out_result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run("arst.divu", 3'd5, 32'd100, 32'd7, 32'd14, DLAT);
    run("arst.mod",  3'd4, 32'd100, 32'hFFFF_FFF9, 32'd2, DLAT);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
